// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the
// opcode decoder. Latches the 8-bit control bundle, operands, register
// addresses and immediate for EX. Detects load-use hazards and turns the
// entering instruction into a bubble. Resolves beq/j in ID and drives the
// PC-write, IF/ID-write and IF/ID-flush enables.
//
// Ports
//   clk_i, rst_i          clock (rising edge) / synchronous active-high reset
//   ctrl_i                decoder bundle: [0] RegWrite, [1] MemtoReg, [7:2] pass
//   branch_i, jump_i      ID instruction is beq / j
//   hold_i                global freeze; all stage state holds
//   rs/rt/rd_addr_i       ID register fields
//   rs/rt_data_i, imm_i   register-file read data, sign-extended immediate
//   ex_*_o                registered EX-side copies of the above
//   ex_valid_o            EX slot holds a real instruction (0 = bubble)
//   pc_write_o            PC may advance            (combinational)
//   ifid_write_o          IF/ID may load            (combinational)
//   ifid_flush_o          IF/ID cleared next edge   (combinational)
//   stall_cnt_o           saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               ctrl_i,
  input  logic                     branch_i,
  input  logic                     jump_i,
  input  logic                     hold_i,
  input  logic [ADDR_W-1:0]        rs_addr_i,
  input  logic [ADDR_W-1:0]        rt_addr_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  input  logic signed [DATA_W-1:0] rs_data_i,
  input  logic signed [DATA_W-1:0] rt_data_i,
  input  logic signed [DATA_W-1:0] imm_i,
  output logic [7:0]               ex_ctrl_o,
  output logic signed [DATA_W-1:0] ex_rs_data_o,
  output logic signed [DATA_W-1:0] ex_rt_data_o,
  output logic signed [DATA_W-1:0] ex_imm_o,
  output logic [ADDR_W-1:0]        ex_rs_addr_o,
  output logic [ADDR_W-1:0]        ex_rt_addr_o,
  output logic [ADDR_W-1:0]        ex_rd_addr_o,
  output logic                     ex_valid_o,
  output logic                     pc_write_o,
  output logic                     ifid_write_o,
  output logic                     ifid_flush_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  logic [7:0]               ex_ctrl_q,    ex_ctrl_d;
  logic signed [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic signed [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic signed [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [ADDR_W-1:0]        ex_rs_addr_q, ex_rs_addr_d;
  logic [ADDR_W-1:0]        ex_rt_addr_q, ex_rt_addr_d;
  logic [ADDR_W-1:0]        ex_rd_addr_q, ex_rd_addr_d;
  logic                     ex_valid_q,   ex_valid_d;
  logic [CNT_W-1:0]         stall_cnt_q,  stall_cnt_d;

  logic lu;
  logic tk;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  // ID stage: hazard detection and branch/jump resolution
  // A load in EX whose destination feeds this instruction must stall one
  // cycle; $0 is hard-wired so it never creates a dependency.
  assign lu = ex_valid_q & ex_ctrl_q[1] & (ex_rt_addr_q != '0) &
              ((ex_rt_addr_q == rs_addr_i) | (ex_rt_addr_q == rt_addr_i));
  assign tk = jump_i | (branch_i & (rs_data_i == rt_data_i));

  // The stall wins over a taken branch: the branch is re-evaluated next
  // cycle, when the ID instruction is still held and the load has moved on.
  assign pc_write_o   = ~lu & ~hold_i;
  assign ifid_write_o = ~lu & ~hold_i;
  assign ifid_flush_o = tk & ~lu & ~hold_i;

  always_comb begin
    ex_rs_data_d = rs_data_i;
    ex_rt_data_d = rt_data_i;
    ex_imm_d     = imm_i;
    ex_rs_addr_d = rs_addr_i;
    ex_rt_addr_d = rt_addr_i;
    ex_rd_addr_d = rd_addr_i;
    ex_ctrl_d    = ctrl_i;
    ex_valid_d   = 1'b1;
    stall_cnt_d  = stall_cnt_q;
    if (lu) begin
      // Bubble: fields still load, but with zero control nothing commits.
      ex_ctrl_d   = '0;
      ex_valid_d  = 1'b0;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_ctrl_q    <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_addr_q <= '0;
      ex_rt_addr_q <= '0;
      ex_rd_addr_q <= '0;
      ex_valid_q   <= 1'b0;
      stall_cnt_q  <= '0;
    end else if (!hold_i) begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_addr_q <= ex_rs_addr_d;
      ex_rt_addr_q <= ex_rt_addr_d;
      ex_rd_addr_q <= ex_rd_addr_d;
      ex_valid_q   <= ex_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ex_ctrl_o    = ex_ctrl_q;
  assign ex_rs_data_o = ex_rs_data_q;
  assign ex_rt_data_o = ex_rt_data_q;
  assign ex_imm_o     = ex_imm_q;
  assign ex_rs_addr_o = ex_rs_addr_q;
  assign ex_rt_addr_o = ex_rt_addr_q;
  assign ex_rd_addr_o = ex_rd_addr_q;
  assign ex_valid_o   = ex_valid_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
